// File: rtl/vga_timing_generator.sv
// VGA timing generator.
//   Scans a pixel position (o_x/o_y) for an external pattern source, decodes
//   active area and sync pulses from it, delays them by PIPE_DELAY clocks to
//   meet the source's colour latency, then registers syncs and blanked RGB
//   together so they stay co-timed at the connector.
// Optional feature: define VGA_FRAME_COUNT_EN to add o_frame_count.
// Ports:
//   i_clk, i_rst_n          pixel clock, async active-low reset
//   o_x, o_y                current column / row counters
//   o_frame_end             high on the last clock of a frame
//   i_red, i_green, i_blue  colour from the source, PIPE_DELAY clocks after o_x/o_y
//   o_vga_hsync/vsync       active-low syncs
//   o_vga_red/green/blue    blanked, aligned colour
//   o_frame_count           completed frames (VGA_FRAME_COUNT_EN only)
module vga_timing_generator #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_frame_end,
  input  logic [2:0]  i_red,
  input  logic [2:0]  i_green,
  input  logic [2:0]  i_blue,
  output logic        o_vga_hsync,
  output logic        o_vga_vsync,
  output logic [2:0]  o_vga_red,
  output logic [2:0]  o_vga_green,
  output logic [2:0]  o_vga_blue
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] o_frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast    = 11'(V_TOTAL - 1);
  localparam logic [10:0] HAct     = 11'(H_ACTIVE);
  localparam logic [10:0] VAct     = 11'(V_ACTIVE);
  localparam logic [10:0] HsStart  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VsStart  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_q, v_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == HLast) begin
      h_q <= '0;
      v_q <= (v_q == VLast) ? 11'd0 : v_q + 11'd1;
    end else begin
      h_q <= h_q + 11'd1;
    end
  end

  assign o_x         = h_q;
  assign o_y         = v_q;
  assign o_frame_end = (h_q == HLast) && (v_q == VLast);

  logic active_raw, hs_raw_n, vs_raw_n;

  always_comb begin
    active_raw = (h_q < HAct) && (v_q < VAct);
    hs_raw_n   = !((h_q >= HsStart) && (h_q < HsEnd));
    vs_raw_n   = !((v_q >= VsStart) && (v_q < VsEnd));
  end

  // Delay line matching the pattern source's colour latency.
  logic active_dly, hs_dly_n, vs_dly_n;

  generate
    if (PIPE_DELAY == 0) begin : g_bypass
      assign active_dly = active_raw;
      assign hs_dly_n   = hs_raw_n;
      assign vs_dly_n   = vs_raw_n;
    end else begin : g_pipe
      logic [PIPE_DELAY-1:0] act_sr, hs_sr, vs_sr;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          act_sr <= '0;
          hs_sr  <= '1;
          vs_sr  <= '1;
        end else begin
          act_sr[0] <= active_raw;
          hs_sr[0]  <= hs_raw_n;
          vs_sr[0]  <= vs_raw_n;
          for (int i = 1; i < int'(PIPE_DELAY); i++) begin
            act_sr[i] <= act_sr[i-1];
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
          end
        end
      end

      assign active_dly = act_sr[PIPE_DELAY-1];
      assign hs_dly_n   = hs_sr[PIPE_DELAY-1];
      assign vs_dly_n   = vs_sr[PIPE_DELAY-1];
    end
  endgenerate

  // Syncs and colour share one register stage so they reach the pins together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vga_hsync <= 1'b1;
      o_vga_vsync <= 1'b1;
      o_vga_red   <= '0;
      o_vga_green <= '0;
      o_vga_blue  <= '0;
    end else begin
      o_vga_hsync <= hs_dly_n;
      o_vga_vsync <= vs_dly_n;
      o_vga_red   <= active_dly ? i_red   : 3'd0;
      o_vga_green <= active_dly ? i_green : 3'd0;
      o_vga_blue  <= active_dly ? i_blue  : 3'd0;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_count <= '0;
    end else if (o_frame_end) begin
      o_frame_count <= o_frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator: three instances (two small
// timings with PIPE_DELAY 2 and 0, one with default timing and PIPE_DELAY 1)
// share random colour stimulus and are compared against a clock-count model.
module tb_vga_timing_generator;

  logic       clk;
  logic       rst_n;
  logic [2:0] red, green, blue;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int red_mode = 0;

  // Colour driven during each cycle since the last reset release.
  logic [8:0] col_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic        a_fe, b_fe, c_fe, a_hs, b_hs, c_hs, a_vs, b_vs, c_vs;
  logic [2:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  logic [15:0] a_fc, b_fc, c_fc;

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(a_x), .o_y(a_y), .o_frame_end(a_fe),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_vga_hsync(a_hs), .o_vga_vsync(a_vs),
    .o_vga_red(a_r), .o_vga_green(a_g), .o_vga_blue(a_b)
`ifdef VGA_FRAME_COUNT_EN
    , .o_frame_count(a_fc)
`endif
  );

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(b_x), .o_y(b_y), .o_frame_end(b_fe),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_vga_hsync(b_hs), .o_vga_vsync(b_vs),
    .o_vga_red(b_r), .o_vga_green(b_g), .o_vga_blue(b_b)
`ifdef VGA_FRAME_COUNT_EN
    , .o_frame_count(b_fc)
`endif
  );

  vga_timing_generator u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(c_x), .o_y(c_y), .o_frame_end(c_fe),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_vga_hsync(c_hs), .o_vga_vsync(c_vs),
    .o_vga_red(c_r), .o_vga_green(c_g), .o_vga_blue(c_b)
`ifdef VGA_FRAME_COUNT_EN
    , .o_frame_count(c_fc)
`endif
  );

`ifndef VGA_FRAME_COUNT_EN
  assign a_fc = 16'd0;
  assign b_fc = 16'd0;
  assign c_fc = 16'd0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, n, got, exp);
    end
  endtask

  // Expected outputs of one instance at clock n after release, derived from
  // the scan position n clocks in and the colour history.
  task automatic check_inst(input string nm, input int ha, input int hf, input int hsw,
                            input int hb, input int va, input int vf, input int vsw,
                            input int vb, input int d, input int cyc,
                            input logic [10:0] x, input logic [10:0] y, input logic fe,
                            input logic hs, input logic vs, input logic [2:0] r,
                            input logic [2:0] g, input logic [2:0] b, input logic [15:0] fc);
    int htot, vtot, px, py, qx, qy, p;
    logic e_hs, e_vs, act;
    logic [8:0] e_rgb;
    htot = ha + hf + hsw + hb;
    vtot = va + vf + vsw + vb;
    px = cyc % htot;
    py = (cyc / htot) % vtot;
    check_eq({nm, ".x"}, 32'(x), 32'(px));
    check_eq({nm, ".y"}, 32'(y), 32'(py));
    check_eq({nm, ".frame_end"}, 32'(fe), 32'((px == htot-1) && (py == vtot-1)));
    if (cyc < d + 1) begin
      e_hs = 1'b1; e_vs = 1'b1; e_rgb = 9'd0;
    end else begin
      p  = cyc - 1 - d;
      qx = p % htot;
      qy = (p / htot) % vtot;
      act  = (qx < ha) && (qy < va);
      e_hs = !((qx >= ha + hf) && (qx < ha + hf + hsw));
      e_vs = !((qy >= va + vf) && (qy < va + vf + vsw));
      e_rgb = act ? col_q[cyc-1] : 9'd0;
    end
    check_eq({nm, ".hsync"}, 32'(hs), 32'(e_hs));
    check_eq({nm, ".vsync"}, 32'(vs), 32'(e_vs));
    check_eq({nm, ".rgb"}, 32'({r, g, b}), 32'(e_rgb));
`ifdef VGA_FRAME_COUNT_EN
    check_eq({nm, ".frame_count"}, 32'(fc), 32'((cyc / (htot * vtot)) % 65536));
`else
    if (fc != 16'd0) check_eq({nm, ".frame_count_tie"}, 32'(fc), 32'd0);
`endif
  endtask

  task automatic check_all(input int cyc);
    check_inst("a", 16, 2, 4, 3, 10, 2, 2, 3, 2, cyc, a_x, a_y, a_fe, a_hs, a_vs,
               a_r, a_g, a_b, a_fc);
    check_inst("b", 16, 2, 4, 3, 10, 2, 2, 3, 0, cyc, b_x, b_y, b_fe, b_hs, b_vs,
               b_r, b_g, b_b, b_fc);
    check_inst("c", 640, 16, 96, 48, 480, 10, 2, 33, 1, cyc, c_x, c_y, c_fe, c_hs, c_vs,
               c_r, c_g, c_b, c_fc);
  endtask

  task automatic drive_colour();
    red   = (red_mode != 0) ? 3'd7 : 3'($urandom_range(0, 7));
    green = 3'($urandom_range(0, 7));
    blue  = 3'($urandom_range(0, 7));
    col_q.push_back({red, green, blue});
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    n = 0;
    col_q.delete();
    drive_colour();
  endtask

  task automatic run_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk);
      #1;
      n++;
      check_all(n);
      drive_colour();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    red = '0; green = '0; blue = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all(0);
    release_reset();
    run_cycles(1000);

    // Mid-frame reset: everything returns to reset values without a clock.
    rst_n = 1'b0;
    #1;
    n = 0;
    check_all(0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all(0);
    end
    release_reset();
    red_mode = 1;
    run_cycles(1700);
    red_mode = 0;
    run_cycles(1700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
